// File: rtl/weight_sort_stream.sv
// weight_sort_stream: streams weight-buffer words as byte-replicated beats; optional WEIGHT_SORT_FLUSH_EN adds a flush port
module weight_sort_stream #(
  parameter int BUF_W  = 32,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef WEIGHT_SORT_FLUSH_EN
  input  logic              flush,
`endif
  input  logic [MODE_W-1:0] input_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BUF_W-1:0]  buffer,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  sorted_data,
  output logic              out_last
);
  localparam int N = BUF_W / 8;
  logic [N-1:0][7:0] word_q;
  logic              full;
  logic [1:0]        phase;
  logic [MODE_W-1:0] mode_q;
  logic [1:0]        last_phase;
  logic              in_fire;
  logic              out_fire;
  assign last_phase = mode_q == '0 ? 2'd0 : mode_q == MODE_W'(1) ? 2'd1 : 2'd3;
  assign out_valid  = full;
  assign out_last   = full & (phase == last_phase);
`ifdef WEIGHT_SORT_FLUSH_EN
  assign in_ready   = !flush & (!full | (out_ready & out_last));
`else
  assign in_ready   = !full | (out_ready & out_last);
`endif
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  // each output lane j takes byte phase*(N/R) + j/R of the held word
  always_comb begin
    sorted_data = '0;
    for (int j = 0; j < N; j++)
      sorted_data[8*j +: 8] = mode_q == '0          ? word_q[j] :
                              mode_q == MODE_W'(1)  ? word_q[int'(phase[0]) * (N/2) + j/2] :
                                                      word_q[int'(phase) * (N/4) + j/4];
  end
  // word/phase sequencing: load on input fire, advance or retire on output fire
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      full   <= 1'b0;
      phase  <= 2'd0;
      mode_q <= '0;
    end
`ifdef WEIGHT_SORT_FLUSH_EN
    else if (flush) begin
      word_q <= '0;
      full   <= 1'b0;
      phase  <= 2'd0;
    end
`endif
    else if (in_fire) begin
      word_q <= buffer;
      mode_q <= input_bitwidth;
      phase  <= 2'd0;
      full   <= 1'b1;
    end else if (out_fire) begin
      if (out_last) begin
        word_q <= '0;
        full   <= 1'b0;
        phase  <= 2'd0;
      end else begin
        phase  <= phase + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_weight_sort_stream.sv
// tb_weight_sort_stream: queue-of-beats model checked every cycle plus directed literal checks
module tb_weight_sort_stream;
  localparam int BUF_W = 32;
  localparam int N = BUF_W / 8;
  typedef struct {logic [BUF_W-1:0] data; logic last;} beat_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [1:0] input_bitwidth = 0;
  logic [BUF_W-1:0] buffer = 0;
  logic in_ready, out_valid, out_last;
  logic [BUF_W-1:0] sorted_data;
`ifdef WEIGHT_SORT_FLUSH_EN
  logic flush = 0;
`endif
  int checks = 0, failures = 0;
  bit chk_en = 0;
  beat_t q[$];

  weight_sort_stream #(.BUF_W(BUF_W), .MODE_W(2)) dut (
    .clk(clk), .reset(reset),
`ifdef WEIGHT_SORT_FLUSH_EN
    .flush(flush),
`endif
    .input_bitwidth(input_bitwidth), .in_valid(in_valid), .in_ready(in_ready),
    .buffer(buffer), .out_valid(out_valid), .out_ready(out_ready),
    .sorted_data(sorted_data), .out_last(out_last));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BUF_W-1:0] got, input logic [BUF_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int rep(input logic [1:0] m);
    return m == 2'd0 ? 1 : m == 2'd1 ? 2 : 4;
  endfunction

  // beat k of word w: slice the word into R equal chunks, repeat every byte of chunk k R times
  function automatic logic [BUF_W-1:0] beat(input logic [BUF_W-1:0] w, input logic [1:0] m, input int k);
    logic [N-1:0][7:0] src, dst;
    int r, pos;
    src = w;
    dst = '0;
    r = rep(m);
    pos = 0;
    for (int s = k * (N / r); s < (k + 1) * (N / r); s++)
      for (int t = 0; t < r; t++) begin
        dst[pos] = src[s];
        pos++;
      end
    return dst;
  endfunction

  // compare against the model head, then advance the model with this cycle's handshakes
  always @(negedge clk) begin
    logic exp_ready;
    logic stop;
    stop = reset;
`ifdef WEIGHT_SORT_FLUSH_EN
    stop = stop | flush;
`endif
    exp_ready = q.size() == 0 || (out_ready && q[0].last);
`ifdef WEIGHT_SORT_FLUSH_EN
    if (flush) exp_ready = 0;
`endif
    if (chk_en) begin
      chk("m_out_valid", BUF_W'(out_valid), BUF_W'(q.size() != 0));
      chk("m_sorted_data", sorted_data, q.size() != 0 ? q[0].data : '0);
      chk("m_out_last", BUF_W'(out_last), BUF_W'(q.size() != 0 && q[0].last));
      chk("m_in_ready", BUF_W'(in_ready), BUF_W'(exp_ready));
    end
    if (stop) q.delete();
    else begin
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && exp_ready)
        for (int k = 0; k < rep(input_bitwidth); k++)
          q.push_back('{beat(buffer, input_bitwidth, k), k == rep(input_bitwidth) - 1});
    end
  end

  task automatic put(input logic [BUF_W-1:0] w, input logic [1:0] m);
    int n = 0;
    in_valid = 1; buffer = w; input_bitwidth = m;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("put_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic lit(input string name, input logic [BUF_W-1:0] d, input logic l, input logic r);
    @(negedge clk);
    chk({name, "_data"}, sorted_data, d);
    chk({name, "_last"}, BUF_W'(out_last), BUF_W'(l));
    chk({name, "_ready"}, BUF_W'(in_ready), BUF_W'(r));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_valid", BUF_W'(out_valid), 0);
    chk("rst_data", sorted_data, 0);
    chk("rst_ready", BUF_W'(in_ready), 1);
    idle(1);
    put(32'hDDCCBBAA, 2'd0);
    lit("m00", 32'hDDCCBBAA, 1, 1);
    idle(1);
    put(32'hDDCCBBAA, 2'd1);
    lit("m01_b0", 32'hBBBBAAAA, 0, 0);
    lit("m01_b1", 32'hDDDDCCCC, 1, 1);
    idle(1);
    for (int m = 2; m < 4; m++) begin
      put(32'hDDCCBBAA, 2'(m));
      lit("m1x_b0", 32'hAAAAAAAA, 0, 0);
      lit("m1x_b1", 32'hBBBBBBBB, 0, 0);
      lit("m1x_b2", 32'hCCCCCCCC, 0, 0);
      lit("m1x_b3", 32'hDDDDDDDD, 1, 1);
      idle(1);
    end
    put(32'hDDCCBBAA, 2'd2);
    lit("bp_b0", 32'hAAAAAAAA, 0, 0);
    idle(1);
    out_ready = 0; input_bitwidth = 2'd0;
    repeat (3) lit("bp_hold", 32'hBBBBBBBB, 0, 0);
    idle(1);
    out_ready = 1;
    lit("bp_b1", 32'hBBBBBBBB, 0, 0);
    lit("bp_b2", 32'hCCCCCCCC, 0, 0);
    lit("bp_b3", 32'hDDDDDDDD, 1, 1);
    idle(1);
    in_valid = 1; buffer = 32'h44332211; input_bitwidth = 2'd1;
    @(negedge clk);
    chk("b2b_ready0", BUF_W'(in_ready), 1);
    idle(1);
    buffer = 32'h88776655;
    lit("b2b_0", 32'h22221111, 0, 0);
    lit("b2b_1", 32'h44443333, 1, 1);
    idle(1);
    in_valid = 0;
    lit("b2b_2", 32'h66665555, 0, 0);
    lit("b2b_3", 32'h88887777, 1, 1);
    idle(1);
    put(32'hDDCCBBAA, 2'd2);
    lit("rm_b0", 32'hAAAAAAAA, 0, 0);
    lit("rm_b1", 32'hBBBBBBBB, 0, 0);
    idle(1);
    reset = 1;
    idle(1);
    reset = 0;
    lit("rm_after", 32'h0, 0, 1);
    chk("rm_valid", BUF_W'(out_valid), 0);
    put(32'h04030201, 2'd2);
    lit("rm_next_b0", 32'h01010101, 0, 0);
    lit("rm_next_b1", 32'h02020202, 0, 0);
`ifdef WEIGHT_SORT_FLUSH_EN
    idle(1);
    flush = 1;
    in_valid = 1; buffer = 32'h55555555;
    @(negedge clk);
    chk("fl_ready", BUF_W'(in_ready), 0);
    idle(1);
    flush = 0; in_valid = 0;
    lit("fl_after", 32'h0, 0, 1);
    chk("fl_valid", BUF_W'(out_valid), 0);
    put(32'h0D0C0B0A, 2'd1);
    lit("fl_next_b0", 32'h0B0B0A0A, 0, 0);
    lit("fl_next_b1", 32'h0D0D0C0C, 1, 1);
`else
    lit("rm_next_b2", 32'h03030303, 0, 0);
    lit("rm_next_b3", 32'h04040404, 1, 1);
`endif
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
